// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access types,
// IO window decode, FSM states and load extension.
package mem_ctrl_pkg;

  localparam logic [2:0] INSTY_LB  = 3'd0;
  localparam logic [2:0] INSTY_LH  = 3'd1;
  localparam logic [2:0] INSTY_LW  = 3'd2;
  localparam logic [2:0] INSTY_LBU = 3'd3;
  localparam logic [2:0] INSTY_LHU = 3'd4;
  localparam logic [2:0] INSTY_SB  = 3'd5;
  localparam logic [2:0] INSTY_SH  = 3'd6;
  localparam logic [2:0] INSTY_SW  = 3'd7;

  localparam logic [1:0] IO_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  function automatic logic is_store(input logic [2:0] t);
    return t[2] && (t[1:0] != 2'b00);
  endfunction

  // Takes address bits [17:16], the only bits that decide the IO window.
  function automatic logic is_io(input logic [1:0] addr_hi);
    return addr_hi == IO_HI;
  endfunction

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_byte(input logic [2:0] t);
    case (t)
      INSTY_LB, INSTY_LBU, INSTY_SB: return 2'd0;
      INSTY_LH, INSTY_LHU, INSTY_SH: return 2'd1;
      default:                       return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [31:0] raw);
    case (t)
      INSTY_LB:  return {{24{raw[7]}}, raw[7:0]};
      INSTY_LH:  return {{16{raw[15]}}, raw[15:0]};
      INSTY_LBU: return {24'd0, raw[7:0]};
      INSTY_LHU: return {16'd0, raw[15:0]};
      default:   return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response and RAM-side byte bus of the memory controller.
interface mem_ctrl_if;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_finished;
  logic [31:0] if_inst;
  logic        ls_valid;
  logic [2:0]  ls_insty;
  logic [31:0] ls_addr;
  logic [31:0] ls_value;
  logic        ls_finished;
  logic [31:0] ls_result;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  if_valid, if_addr, ls_valid, ls_insty, ls_addr, ls_value, mem_din, io_buffer_full,
    output if_finished, if_inst, ls_finished, ls_result, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_valid, if_addr, ls_valid, ls_insty, ls_addr, ls_value, mem_din, io_buffer_full,
    input  if_finished, if_inst, ls_finished, ls_result, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto a byte-wide RAM/IO port and
// serializes each access into 1/2/4 byte transfers with registered outputs.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      jump_wrong,
  mem_ctrl_if.slave bus,
  output state_t    dbg_state
);

  // Handshake: a requester holds *_valid with stable fields until its
  // *_finished pulse; requests are sampled only in IDLE, and the one-cycle
  // *_finished pulse is the sole acknowledgement (no separate ready).

  state_t      state, next_state;
  logic        last_was_ls;
  logic [31:0] addr_q, data_q;
  logic [2:0]  op_q;
  logic [1:0]  issue_idx, rx_cnt;
  logic        issuing, rx_valid;
  logic        grant_ls, grant_if, rx_last, wr_last;
  logic [1:0]  last_idx, next_idx;
  logic [31:0] next_addr, rx_word;

  assign grant_ls  = (state == ST_IDLE) && !jump_wrong && bus.ls_valid &&
                     (!bus.if_valid || !last_was_ls);
  assign grant_if  = (state == ST_IDLE) && !jump_wrong && bus.if_valid &&
                     (!bus.ls_valid || last_was_ls);
  assign last_idx  = last_byte(op_q);
  assign next_idx  = issue_idx + 2'd1;
  assign next_addr = addr_q + {30'd0, next_idx};
  assign rx_last   = rx_valid && (rx_cnt == last_idx);
  assign wr_last   = bus.mem_wr && (issue_idx == last_idx);
  assign dbg_state = state;

  // Word assembled so far with the byte arriving this cycle merged in.
  always_comb begin
    rx_word = data_q;
    rx_word[{rx_cnt, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk) begin
    if (!rst)     state <= ST_IDLE;
    else if (rdy) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (grant_ls)      next_state = is_store(bus.ls_insty) ? ST_STORE : ST_LOAD;
        else if (grant_if) next_state = ST_FETCH;
      end
      ST_FETCH, ST_LOAD: if (jump_wrong || rx_last) next_state = ST_IDLE;
      ST_STORE:          if (wr_last) next_state = ST_IDLE;
      default:           next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mem_a       <= '0;
      bus.mem_dout    <= '0;
      bus.mem_wr      <= 1'b0;
      bus.if_finished <= 1'b0;
      bus.ls_finished <= 1'b0;
      bus.if_inst     <= '0;
      bus.ls_result   <= '0;
      last_was_ls     <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      op_q            <= INSTY_LB;
      issue_idx       <= '0;
      rx_cnt          <= '0;
      issuing         <= 1'b0;
      rx_valid        <= 1'b0;
    end else if (rdy) begin
      bus.if_finished <= 1'b0;
      bus.ls_finished <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.mem_a  <= '0;
          bus.mem_wr <= 1'b0;
          if (grant_ls || grant_if) begin
            addr_q       <= grant_ls ? bus.ls_addr : bus.if_addr;
            op_q         <= grant_ls ? bus.ls_insty : INSTY_LW;
            data_q       <= bus.ls_value;
            last_was_ls  <= grant_ls;
            bus.mem_a    <= grant_ls ? bus.ls_addr : bus.if_addr;
            bus.mem_dout <= bus.ls_value[7:0];
            bus.mem_wr   <= grant_ls && is_store(bus.ls_insty) &&
                            !(is_io(bus.ls_addr[17:16]) && bus.io_buffer_full);
            issue_idx    <= '0;
            rx_cnt       <= '0;
            issuing      <= 1'b1;
            rx_valid     <= 1'b0;
          end
        end
        ST_FETCH, ST_LOAD: begin
          if (jump_wrong) begin
            bus.mem_a <= '0;
            issuing   <= 1'b0;
            rx_valid  <= 1'b0;
          end else begin
            // The RAM answers one cycle after the address, so receive lags issue.
            rx_valid <= issuing;
            if (issuing) begin
              if (issue_idx == last_idx) begin
                issuing   <= 1'b0;
                bus.mem_a <= '0;
              end else begin
                issue_idx <= next_idx;
                bus.mem_a <= next_addr;
              end
            end
            if (rx_valid) begin
              data_q <= rx_word;
              rx_cnt <= rx_cnt + 2'd1;
              if (rx_cnt == last_idx) begin
                if (state == ST_FETCH) begin
                  bus.if_finished <= 1'b1;
                  bus.if_inst     <= rx_word;
                end else begin
                  bus.ls_finished <= 1'b1;
                  bus.ls_result   <= load_extend(op_q, rx_word);
                end
              end
            end
          end
        end
        ST_STORE: begin
          if (bus.mem_wr) begin
            if (issue_idx == last_idx) begin
              bus.mem_wr      <= 1'b0;
              bus.mem_a       <= '0;
              bus.ls_finished <= 1'b1;
            end else begin
              issue_idx    <= next_idx;
              bus.mem_a    <= next_addr;
              bus.mem_dout <= data_q[{next_idx, 3'b000} +: 8];
              bus.mem_wr   <= !(is_io(next_addr[17:16]) && bus.io_buffer_full);
            end
          end else begin
            // Held byte waits for room in the IO output FIFO.
            bus.mem_wr <= !(is_io(bus.mem_a[17:16]) && bus.io_buffer_full);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
